// File: rtl/output_port_arbiter_pkg.sv
// Shared router definitions: port count, port index constants, arbiter state encoding.
package output_port_arbiter_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned IDX_W     = 3;

    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_N     = 1;
    localparam int unsigned PORT_E     = 2;
    localparam int unsigned PORT_S     = 3;
    localparam int unsigned PORT_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Round-robin successor of a port index, wrapping at the last port.
    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant and flit handshake bundle between the input buffers, the arbiter and the output link.
interface output_port_arbiter_if;
    import output_port_arbiter_pkg::*;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] in_valid;
    logic [NUM_PORTS-1:0] in_tail;
    logic                 out_ready;
    logic [NUM_PORTS-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_vld;
    logic [NUM_PORTS-1:0] in_ready;
    logic                 out_valid;

    modport master (
        output req, in_valid, in_tail, out_ready,
        input  grant, grant_idx, grant_vld, in_ready, out_valid
    );

    modport slave (
        input  req, in_valid, in_tail, out_ready,
        output grant, grant_idx, grant_vld, in_ready, out_valid
    );

endinterface

// File: rtl/output_port_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping around.
module rr_priority_pick
    import output_port_arbiter_pkg::*;
#(
    parameter int unsigned REQ_N = NUM_PORTS,
    parameter int unsigned PTR_W = IDX_W
) (
    input  logic [REQ_N-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [REQ_N-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             vld_o
);

    localparam int unsigned CW = PTR_W + 1;

    logic [CW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < REQ_N; k++) begin
            cand = {1'b0, ptr_i} + CW'(k);
            if (cand >= CW'(REQ_N)) begin
                cand = cand - CW'(REQ_N);
            end
            if (!vld_o && req_i[cand[PTR_W-1:0]]) begin
                vld_o                  = 1'b1;
                idx_o                  = cand[PTR_W-1:0];
                gnt_o[cand[PTR_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: holds a one-hot grant from head to tail, round-robin between packets.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output_port_arbiter_if.slave   bus
);

    arb_state_e           state_q;
    logic [NUM_PORTS-1:0] grant_q;
    logic [IDX_W-1:0]     grant_idx_q;
    logic                 grant_vld_q;
    logic [IDX_W-1:0]     ptr_q;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic                 xfer;

    rr_priority_pick #(
        .REQ_N (NUM_PORTS),
        .PTR_W (IDX_W)
    ) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    assign xfer = bus.in_valid[grant_idx_q] & bus.out_ready;

    // Grant is taken in IDLE and only released by a transferred tail flit on the granted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q     <= pick_gnt;
                        grant_idx_q <= pick_idx;
                        grant_vld_q <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer && bus.in_tail[grant_idx_q]) begin
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        ptr_q       <= next_port(grant_idx_q);
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    grant_q     <= '0;
                    grant_vld_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.grant_vld = grant_vld_q;
    assign bus.in_ready  = grant_q & {NUM_PORTS{bus.out_ready}};
    assign bus.out_valid = grant_vld_q & bus.in_valid[grant_idx_q];

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule
